hazard_ctrl_mc: RTL and testbench
=================================

// Module: hazard_ctrl_mc
// PURPOSE
//  Next-gen pipeline hazard unit for the 5-stage core (F/D/E/M/W). It resolves RAW forwarding, load-use and
//  D-stage branch stalls, and adds multi-cycle mul/div holds in E, data-memory wait stalls in M and exception flush.
//  Sits beside the datapath; drives every stage's stall/flush enable and the forwarding muxes.
// PARAMETERS
//  REG_AW  5   register index width; index 0 is hardwired zero and is never forwarded or a hazard source
//  MD_LAT  32  mul/div residency in E, in cycles (>=2); holds E for MD_LAT-1 stall cycles
//  PERF_W  32  width of stall performance counters (HAZARD_PERF_EN only)
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       asynchronous reset, active low
//  rsD,rtD      in   REG_AW  D-stage source regs
//  rsE,rtE      in   REG_AW  E-stage source regs
//  writeRegE/M/W in  REG_AW  destination reg per stage
//  regWriteE/M/W in  1       stage writes the register file
//  memToRegE/M  in   1       stage holds a load
//  branchD      in   1       branch/jr resolving in D
//  mdE          in   1       mul/div instruction in E
//  memReqM      in   1       M-stage data memory access
//  memReadyM    in   1       data memory completes this cycle
//  flushAll     in   1       exception/eret redirect
//  stallF,stallD,stallE,stallM out 1   hold stage register
//  flushD,flushE,flushM,flushW out 1   bubble stage register
//  forward1D,forward2D out 1   D compare operand from M
//  forward1E,forward2E out 2   00 regfile, 01 from W, 10 from M
//  mdBusy       out  1       mul/div FSM in BUSY
//  mdDoneE      out  1       mul/div result valid in E this cycle
//  perfMdStall,perfMemStall,perfDataStall out PERF_W  stall cycle counters
// BEHAVIOUR
//  Forwarding (comb.): E source s != 0: s==writeRegM&regWriteM -> 10; else s==writeRegW&regWriteW -> 01; else 00.
//   forwardxD = (s!=0)&(s==writeRegM)&regWriteM.
//  lwStall = memToRegE&(rtE!=0)&(rtE==rsD|rtE==rtD).
//  brStall = branchD&(regWriteE&(writeRegE!=0)&(writeRegE==rsD|writeRegE==rtD) | memToRegM&(writeRegM==rsD|writeRegM==rtD)).
//  memStall = memReqM&~memReadyM.
//  mul/div FSM, states IDLE/BUSY, counter cnt (clog2(MD_LAT) bits):
//   IDLE & mdE & ~flushAll & ~memStall: -> BUSY, cnt<=MD_LAT-1; mdStall=1 this cycle.
//   BUSY: if ~memStall, cnt<=cnt-1; mdStall=(cnt>1); at cnt==1: mdDoneE=1, ->IDLE, instruction leaves E next edge.
//   memStall freezes FSM and cnt. Back-to-back mdE restarts from IDLE the following cycle.
//   flushAll: ->IDLE, cnt<=0 at next edge, whatever state.
//  Priority (high->low): flushAll, memStall, mdStall, lwStall|brStall.
//   flushAll: flushD=flushE=flushM=1, all stalls 0.
//   memStall: stallF=D=E=M=1, flushW=1, other flushes 0.
//   mdStall: stallF=D=E=1, flushM=1.
//   lw|br: stallF=D=1, flushE=1.
//   none: all 0. flushE is never 1 while stallE is 1.
//  Reset (rst_n low, async): state IDLE, cnt 0, mdBusy 0, mdDoneE 0, perf counters 0.
//   Comb. outputs then follow inputs with FSM in IDLE.
// CONFIGURATION
//  HAZARD_PERF_EN defined: each cycle with memStall / mdStall (unmasked) / lw|br stall (unmasked)
//   increments its counter, saturating at all-ones. flushAll does not clear them; only rst_n does.
//  Undefined: counter logic absent, perf ports tied to 0.
// TESTING
//  rsE=3,writeRegM=3,regWriteM=1,writeRegW=3,regWriteW=1 -> forward1E=10; rsE=0 same -> 00.
//  Load r5 in E, D reads rt=5 -> stallF=stallD=flushE=1 for 1 cycle, then forward2E=10.
//  mdE pulse, MD_LAT=4 -> stallE=1 for 3 cycles, mdDoneE=1 on 4th, mdBusy 0 after.
//  MD busy cnt=2 with memReqM=1,memReadyM=0 for 2 cycles -> stallM=1,flushW=1, cnt frozen; mdDoneE 2 cycles later.
//  flushAll during BUSY -> next cycle mdBusy=0; that cycle flushD/E/M=1, stalls 0.
//  HAZARD_PERF_EN: 5 memStall cycles -> perfMemStall=5. rst_n low mid-BUSY -> mdBusy=0 immediately, counters 0.

Source files
------------

// File: rtl/hazard_ctrl_mc_if.sv
// Hazard unit <-> datapath bundle: stage register/source indices in,
// stall/flush/forward controls and perf counters out.
interface hazard_ctrl_mc_if #(
  parameter int REG_AW = 5,
  parameter int PERF_W = 32
);
  logic [REG_AW-1:0] rsD, rtD, rsE, rtE;
  logic [REG_AW-1:0] writeRegE, writeRegM, writeRegW;
  logic regWriteE, regWriteM, regWriteW;
  logic memToRegE, memToRegM;
  logic branchD, mdE, memReqM, memReadyM, flushAll;
  logic stallF, stallD, stallE, stallM;
  logic flushD, flushE, flushM, flushW;
  logic forward1D, forward2D;
  logic [1:0] forward1E, forward2E;
  logic mdBusy, mdDoneE;
  logic [PERF_W-1:0] perfMdStall, perfMemStall, perfDataStall;

  modport master (
    output rsD, rtD, rsE, rtE,
    output writeRegE, writeRegM, writeRegW,
    output regWriteE, regWriteM, regWriteW,
    output memToRegE, memToRegM,
    output branchD, mdE, memReqM, memReadyM, flushAll,
    input  stallF, stallD, stallE, stallM,
    input  flushD, flushE, flushM, flushW,
    input  forward1D, forward2D, forward1E, forward2E,
    input  mdBusy, mdDoneE,
    input  perfMdStall, perfMemStall, perfDataStall
  );

  modport slave (
    input  rsD, rtD, rsE, rtE,
    input  writeRegE, writeRegM, writeRegW,
    input  regWriteE, regWriteM, regWriteW,
    input  memToRegE, memToRegM,
    input  branchD, mdE, memReqM, memReadyM, flushAll,
    output stallF, stallD, stallE, stallM,
    output flushD, flushE, flushM, flushW,
    output forward1D, forward2D, forward1E, forward2E,
    output mdBusy, mdDoneE,
    output perfMdStall, perfMemStall, perfDataStall
  );
endinterface

// File: rtl/hazard_ctrl_mc.sv
// 5-stage hazard unit: forwarding, load-use/branch stalls, mul/div hold,
// memory wait and exception flush. HAZARD_PERF_EN adds stall counters.
module hazard_ctrl_mc #(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 32,
  parameter int PERF_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  hazard_ctrl_mc_if.slave hz
);
  localparam int CW = $clog2(MD_LAT);
  localparam logic [REG_AW-1:0] R0 = '0;

  typedef enum logic {IDLE, BUSY} md_st_e;

  md_st_e st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mem_stall, md_start, md_stall;
  logic lw_stall, br_stall, ld_stall;

  always_comb begin
    hz.forward1E = 2'b00;
    hz.forward2E = 2'b00;
    if (hz.rsE != R0 && hz.rsE == hz.writeRegM && hz.regWriteM)
      hz.forward1E = 2'b10;
    else if (hz.rsE != R0 && hz.rsE == hz.writeRegW && hz.regWriteW)
      hz.forward1E = 2'b01;
    if (hz.rtE != R0 && hz.rtE == hz.writeRegM && hz.regWriteM)
      hz.forward2E = 2'b10;
    else if (hz.rtE != R0 && hz.rtE == hz.writeRegW && hz.regWriteW)
      hz.forward2E = 2'b01;
  end

  assign hz.forward1D = (hz.rsD != R0) && (hz.rsD == hz.writeRegM)
                        && hz.regWriteM;
  assign hz.forward2D = (hz.rtD != R0) && (hz.rtD == hz.writeRegM)
                        && hz.regWriteM;

  assign lw_stall = hz.memToRegE && (hz.rtE != R0)
                    && (hz.rtE == hz.rsD || hz.rtE == hz.rtD);
  assign br_stall = hz.branchD && (
      (hz.regWriteE && (hz.writeRegE != R0)
       && (hz.writeRegE == hz.rsD || hz.writeRegE == hz.rtD))
    || (hz.memToRegM
       && (hz.writeRegM == hz.rsD || hz.writeRegM == hz.rtD)));
  assign ld_stall = lw_stall || br_stall;
  assign mem_stall = hz.memReqM && !hz.memReadyM;

  assign md_start = (st_q == IDLE) && hz.mdE
                    && !hz.flushAll && !mem_stall;
  assign md_stall = md_start
                    || (st_q == BUSY && cnt_q > CW'(1));
  assign hz.mdBusy = (st_q == BUSY);
  assign hz.mdDoneE = (st_q == BUSY) && (cnt_q == CW'(1))
                      && !mem_stall && !hz.flushAll;

  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    if (hz.flushAll) begin
      st_d = IDLE;
      cnt_d = '0;
    end else if (!mem_stall) begin
      unique case (st_q)
        IDLE: if (hz.mdE) begin
          st_d = BUSY;
          cnt_d = CW'(MD_LAT - 1);
        end
        BUSY: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) st_d = IDLE;
        end
        default: st_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= IDLE;
      cnt_q <= '0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
    end
  end

  // stall above a stage is never paired with a bubble into that stage
  always_comb begin
    {hz.stallF, hz.stallD, hz.stallE, hz.stallM} = 4'b0000;
    {hz.flushD, hz.flushE, hz.flushM, hz.flushW} = 4'b0000;
    if (hz.flushAll) begin
      {hz.flushD, hz.flushE, hz.flushM} = 3'b111;
    end else if (mem_stall) begin
      {hz.stallF, hz.stallD, hz.stallE, hz.stallM} = 4'b1111;
      hz.flushW = 1'b1;
    end else if (md_stall) begin
      {hz.stallF, hz.stallD, hz.stallE} = 3'b111;
      hz.flushM = 1'b1;
    end else if (ld_stall) begin
      {hz.stallF, hz.stallD} = 2'b11;
      hz.flushE = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] pmd_q, pmd_d, pmem_q, pmem_d, pdat_q, pdat_d;

  always_comb begin
    pmd_d = pmd_q;
    pmem_d = pmem_q;
    pdat_d = pdat_q;
    if (md_stall && pmd_q != '1) pmd_d = pmd_q + 1'b1;
    if (mem_stall && pmem_q != '1) pmem_d = pmem_q + 1'b1;
    if (ld_stall && pdat_q != '1) pdat_d = pdat_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pmd_q <= '0;
      pmem_q <= '0;
      pdat_q <= '0;
    end else begin
      pmd_q <= pmd_d;
      pmem_q <= pmem_d;
      pdat_q <= pdat_d;
    end
  end

  assign hz.perfMdStall = pmd_q;
  assign hz.perfMemStall = pmem_q;
  assign hz.perfDataStall = pdat_q;
`else
  assign hz.perfMdStall = {PERF_W{1'b0}};
  assign hz.perfMemStall = {PERF_W{1'b0}};
  assign hz.perfDataStall = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench for hazard_ctrl_mc: stimulus pushes expected outputs,
// a negedge monitor pops and compares them.
module tb_hazard_ctrl_mc;
  localparam int REG_AW = 5;
  localparam int MD_LAT = 4;
  localparam int PERF_W = 32;
`ifdef HAZARD_PERF_EN
  localparam int PM5 = 5;
`else
  localparam int PM5 = 0;
`endif

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] fl;
    logic [1:0] fd;
    logic [1:0] f1e;
    logic [1:0] f2e;
    logic busy;
    logic done;
  } vec_t;

  typedef struct packed {
    vec_t v;
    logic cp;
    logic [PERF_W-1:0] pmem;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int passed = 0;
  exp_t q[$];
  string nq[$];

  hazard_ctrl_mc_if #(.REG_AW(REG_AW), .PERF_W(PERF_W)) hz ();

  hazard_ctrl_mc #(
    .REG_AW(REG_AW), .MD_LAT(MD_LAT), .PERF_W(PERF_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .hz(hz.slave)
  );

  always #5 clk = ~clk;

  task automatic clr();
    hz.rsD = '0; hz.rtD = '0; hz.rsE = '0; hz.rtE = '0;
    hz.writeRegE = '0; hz.writeRegM = '0; hz.writeRegW = '0;
    hz.regWriteE = 0; hz.regWriteM = 0; hz.regWriteW = 0;
    hz.memToRegE = 0; hz.memToRegM = 0;
    hz.branchD = 0; hz.mdE = 0; hz.memReqM = 0;
    hz.memReadyM = 0; hz.flushAll = 0;
  endtask

  task automatic cyc(
    input string n,
    input logic [3:0] st, input logic [3:0] fl,
    input logic [1:0] fd, input logic [1:0] f1,
    input logic [1:0] f2, input logic b, input logic d,
    input logic cp = 1'b0, input int pm = 0
  );
    exp_t e;
    e.v = '{st: st, fl: fl, fd: fd, f1e: f1, f2e: f2,
            busy: b, done: d};
    e.cp = cp;
    e.pmem = PERF_W'(pm);
    q.push_back(e);
    nq.push_back(n);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      string n;
      vec_t a;
      e = q.pop_front();
      n = nq.pop_front();
      a.st = {hz.stallF, hz.stallD, hz.stallE, hz.stallM};
      a.fl = {hz.flushD, hz.flushE, hz.flushM, hz.flushW};
      a.fd = {hz.forward1D, hz.forward2D};
      a.f1e = hz.forward1E;
      a.f2e = hz.forward2E;
      a.busy = hz.mdBusy;
      a.done = hz.mdDoneE;
      total++;
      if (a === e.v) passed++;
      else $display("FAIL %s: got %h want %h", n, a, e.v);
      if (e.cp) begin
        total++;
        if (hz.perfMemStall === e.pmem && hz.perfMdStall === '0
            && hz.perfDataStall === '0) passed++;
        else $display("FAIL %s_perf: got mem=%0d md=%0d dat=%0d want mem=%0d md=0 dat=0",
                      n, hz.perfMemStall, hz.perfMdStall,
                      hz.perfDataStall, e.pmem);
      end
    end
  end

  initial begin
    clr();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc("reset", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    rst_n = 1'b1;

    hz.rsE = 3; hz.writeRegM = 3; hz.regWriteM = 1;
    hz.writeRegW = 3; hz.regWriteW = 1;
    cyc("fwd_m", 0, 0, 0, 2'b10, 0, 0, 0);
    hz.rsE = 0;
    cyc("fwd_r0", 0, 0, 0, 0, 0, 0, 0);
    clr();
    hz.rsE = 7; hz.rtE = 7; hz.writeRegW = 7; hz.regWriteW = 1;
    hz.writeRegM = 7;
    cyc("fwd_w", 0, 0, 0, 2'b01, 2'b01, 0, 0);
    clr();
    hz.rsD = 4; hz.rtD = 4; hz.writeRegM = 4; hz.regWriteM = 1;
    cyc("fwd_d", 0, 0, 2'b11, 0, 0, 0, 0);

    clr();
    hz.memToRegE = 1; hz.regWriteE = 1; hz.writeRegE = 5;
    hz.rtE = 5; hz.rtD = 5;
    cyc("lw_stall", 4'b1100, 4'b0100, 0, 0, 0, 0, 0);
    clr();
    hz.memToRegM = 1; hz.regWriteM = 1; hz.writeRegM = 5; hz.rtE = 5;
    cyc("lw_fwd", 0, 0, 0, 0, 2'b10, 0, 0);

    clr();
    hz.branchD = 1; hz.rsD = 6; hz.writeRegE = 6; hz.regWriteE = 1;
    cyc("br_e", 4'b1100, 4'b0100, 0, 0, 0, 0, 0);
    clr();
    hz.branchD = 1; hz.regWriteE = 1;
    cyc("br_r0", 0, 0, 0, 0, 0, 0, 0);
    clr();
    hz.branchD = 1; hz.rtD = 9; hz.writeRegM = 9;
    hz.memToRegM = 1; hz.regWriteM = 1;
    cyc("br_m", 4'b1100, 4'b0100, 2'b01, 0, 0, 0, 0);

    clr();
    hz.mdE = 1;
    cyc("md_start", 4'b1110, 4'b0010, 0, 0, 0, 0, 0);
    cyc("md_c3", 4'b1110, 4'b0010, 0, 0, 0, 1, 0);
    cyc("md_c2", 4'b1110, 4'b0010, 0, 0, 0, 1, 0);
    cyc("md_done", 0, 0, 0, 0, 0, 1, 1);
    hz.mdE = 0;
    cyc("md_idle", 0, 0, 0, 0, 0, 0, 0);

    hz.mdE = 1;
    cyc("mdm_start", 4'b1110, 4'b0010, 0, 0, 0, 0, 0);
    cyc("mdm_c3", 4'b1110, 4'b0010, 0, 0, 0, 1, 0);
    hz.memReqM = 1;
    cyc("mdm_frz1", 4'b1111, 4'b0001, 0, 0, 0, 1, 0);
    cyc("mdm_frz2", 4'b1111, 4'b0001, 0, 0, 0, 1, 0);
    hz.memReqM = 0;
    cyc("mdm_c2", 4'b1110, 4'b0010, 0, 0, 0, 1, 0);
    cyc("mdm_done", 0, 0, 0, 0, 0, 1, 1);
    hz.mdE = 0;
    cyc("mdm_idle", 0, 0, 0, 0, 0, 0, 0);

    hz.mdE = 1;
    cyc("fl_start", 4'b1110, 4'b0010, 0, 0, 0, 0, 0);
    cyc("fl_c3", 4'b1110, 4'b0010, 0, 0, 0, 1, 0);
    hz.flushAll = 1;
    cyc("fl_busy", 0, 4'b1110, 0, 0, 0, 1, 0);
    hz.flushAll = 0; hz.mdE = 0;
    cyc("fl_after", 0, 0, 0, 0, 0, 0, 0);

    clr();
    hz.flushAll = 1; hz.memReqM = 1; hz.mdE = 1;
    hz.memToRegE = 1; hz.rtE = 2; hz.rsD = 2;
    cyc("fl_prio", 0, 4'b1110, 0, 0, 0, 0, 0);
    clr();
    cyc("fl_no_md", 0, 0, 0, 0, 0, 0, 0);

    hz.mdE = 1;
    cyc("rb_start", 4'b1110, 4'b0010, 0, 0, 0, 0, 0);
    hz.mdE = 0;
    rst_n = 1'b0;
    cyc("rst_busy", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    rst_n = 1'b1;

    hz.memReqM = 1;
    repeat (5) cyc("mem_stall", 4'b1111, 4'b0001, 0, 0, 0, 0, 0);
    hz.memReadyM = 1;
    cyc("mem_ready", 0, 0, 0, 0, 0, 0, 0, 1, PM5);
    clr();

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      total++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
